alu_accumulator_seq: RTL and testbench

Parametrised successor to the 8-bit accumulator and add/sub pair. It merges the accumulator register, ALU, flags and bus driver into one block with a valid/ready operation handshake. Ops cover load, add/sub with and without carry-in, logic, and a multi-cycle shift-add multiply. It sits on the shared tri-state data bus as the CPU's A register and ALU.

---
 rtl/alu_accumulator_seq.sv | 146 ++++++++++++++
 tb/tb_alu_accumulator_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_accumulator_seq.sv
// Accumulator register + ALU + flags + bus driver with valid/ready op handshake.
// Single-cycle ops commit at the accept edge; MUL commits WIDTH edges after accept.
module alu_accumulator_seq #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] operand,
    input  logic             enable_output,
    inout  wire  [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] prod_hi,
    output logic             done,
    output logic             CF,
    output logic             ZF,
    output logic             NF,
    output logic             VF
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_ADC  = 3'b011;
    localparam logic [2:0] OP_SBB  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   prod;

    logic                 is_sub;
    logic [WIDTH-1:0]     b_eff;
    logic                 cin;
    logic [WIDTH:0]       sum;
    logic                 arith_vf;
    logic [WIDTH-1:0]     logic_res;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       hi_sum;
    logic [2*WIDTH-1:0]   prod_next;

    assign op_ready = (state == ST_IDLE) && !rst;
    assign bus      = enable_output ? acc : {WIDTH{1'bz}};

    always_comb begin
        is_sub = (op_code == OP_SUB) || (op_code == OP_SBB);
        b_eff  = is_sub ? ~operand : operand;
        case (op_code)
            OP_SUB:          cin = 1'b1;
            OP_ADC, OP_SBB:  cin = CF;
            default:         cin = 1'b0;
        endcase
        sum       = {1'b0, acc} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        arith_vf  = (acc[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
        logic_res = (op_code == OP_AND) ? (acc & operand) : (acc ^ operand);
        // Right-shifting shift-add: add into the upper half, then shift the whole product down.
        addend    = mplier[0] ? mcand : {WIDTH{1'b0}};
        hi_sum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        prod_next = {hi_sum, prod[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            prod    <= '0;
            acc     <= '0;
            prod_hi <= '0;
            done    <= 1'b0;
            CF      <= 1'b0;
            ZF      <= 1'b0;
            NF      <= 1'b0;
            VF      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (op_code)
                            OP_LOAD: begin
                                acc  <= operand;
                                ZF   <= (operand == '0);
                                NF   <= operand[WIDTH-1];
                                done <= 1'b1;
                            end
                            OP_ADD, OP_SUB, OP_ADC, OP_SBB: begin
                                acc  <= sum[WIDTH-1:0];
                                CF   <= sum[WIDTH];
                                VF   <= arith_vf;
                                ZF   <= (sum[WIDTH-1:0] == '0);
                                NF   <= sum[WIDTH-1];
                                done <= 1'b1;
                            end
                            OP_AND, OP_XOR: begin
                                acc  <= logic_res;
                                CF   <= 1'b0;
                                VF   <= 1'b0;
                                ZF   <= (logic_res == '0);
                                NF   <= logic_res[WIDTH-1];
                                done <= 1'b1;
                            end
                            default: begin
                                if (MUL_EN) begin
                                    mcand  <= acc;
                                    mplier <= operand;
                                    prod   <= '0;
                                    cnt    <= CW'(WIDTH);
                                    state  <= ST_MUL;
                                end else begin
                                    done <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    prod   <= prod_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        acc     <= prod_next[WIDTH-1:0];
                        prod_hi <= prod_next[2*WIDTH-1:WIDTH];
                        ZF      <= (prod_next == '0);
                        NF      <= prod_next[WIDTH-1];
                        CF      <= |prod_next[2*WIDTH-1:WIDTH];
                        VF      <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_accumulator_seq.sv
// Directed bench for alu_accumulator_seq (WIDTH=8, MUL_EN=1) with hand-computed expectations.
module tb_alu_accumulator_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [2:0] op_code = 3'b000;
    logic [7:0] operand = 8'h00;
    logic       enable_output = 1'b0;
    wire  [7:0] bus;
    logic [7:0] acc;
    logic [7:0] prod_hi;
    logic       done, CF, ZF, NF, VF;
    logic       ext_en = 1'b0;
    logic [7:0] ext_drv = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [2:0] LOAD = 3'd0, ADD = 3'd1, SUB = 3'd2, ADC = 3'd3,
                           SBB = 3'd4, AND_ = 3'd5, XOR_ = 3'd6, MUL = 3'd7;

    assign bus = ext_en ? ext_drv : 8'hzz;

    alu_accumulator_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .operand(operand), .enable_output(enable_output),
        .bus(bus), .acc(acc), .prod_hi(prod_hi), .done(done),
        .CF(CF), .ZF(ZF), .NF(NF), .VF(VF)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single edge; returns #1 after the accept edge.
    task automatic issue(input logic [2:0] code, input logic [7:0] opnd);
        op_valid = 1'b1;
        op_code  = code;
        operand  = opnd;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic [3:0] cznv);
        check({tag, "_flags"}, {28'd0, CF, ZF, NF, VF}, {28'd0, cznv});
    endtask

    initial begin
        int busy;
        int edges;
        int acc_moved;
        int dones;

        // Reset
        tick();
        check("rdy_in_rst", op_ready, 1'b0);
        tick();
        check("rst_acc", acc, 8'h00);
        check("rst_prod_hi", prod_hi, 8'h00);
        check("rst_done", done, 1'b0);
        check_flags("rst", 4'b0000);
        rst = 1'b0;
        #1;
        check("rdy_after_rst", op_ready, 1'b1);

        // Carry / zero, done pulse once per op
        issue(LOAD, 8'hFF);
        check("load_ff_done", done, 1'b1);
        check("load_ff_acc", acc, 8'hFF);
        issue(ADD, 8'h01);
        check("add_done_b2b", done, 1'b1);
        check("add_acc", acc, 8'h00);
        check_flags("add", 4'b1100);
        tick();
        check("done_drops", done, 1'b0);
        issue(ADC, 8'h10);
        check("adc_acc", acc, 8'h11);
        check_flags("adc", 4'b0000);
        tick();
        check("adc_done_once", done, 1'b0);

        // Overflow / borrow
        issue(LOAD, 8'h7F);
        issue(ADD, 8'h01);
        check("ovf_acc", acc, 8'h80);
        check_flags("ovf", 4'b0011);
        issue(LOAD, 8'h05);
        issue(SUB, 8'h07);
        check("sub_acc", acc, 8'hFE);
        check_flags("sub", 4'b0010);
        issue(SBB, 8'h00);
        check("sbb_acc", acc, 8'hFD);
        check_flags("sbb", 4'b1010);

        // LOAD keeps CF/VF (CF=1 from SBB)
        issue(LOAD, 8'h00);
        check_flags("load_hold", 4'b1100);

        // Logic
        issue(LOAD, 8'hF0);
        issue(XOR_, 8'hFF);
        check("xor_acc", acc, 8'h0F);
        check_flags("xor", 4'b0000);
        issue(AND_, 8'hF0);
        check("and_acc", acc, 8'h00);
        check_flags("and", 4'b0100);

        // MUL 0x1F * 0x11 = 0x020F
        issue(LOAD, 8'h1F);
        issue(MUL, 8'h11);
        busy = 0;
        edges = 0;
        acc_moved = 0;
        while (!done && edges < 20) begin
            if (!op_ready) busy++;
            if (acc !== 8'h1F) acc_moved++;
            if (edges == 3) begin
                check("mul_mid_acc", acc, 8'h1F);
                op_valid = 1'b1;
                op_code  = ADD;
                operand  = 8'h01;
            end
            tick();
            op_valid = 1'b0;
            edges++;
        end
        check("mul_latency", edges, 8);
        check("mul_busy_cycles", busy, 8);
        check("mul_acc_held", acc_moved, 0);
        check("mul_acc", acc, 8'h0F);
        check("mul_prod_hi", prod_hi, 8'h02);
        check_flags("mul", 4'b1000);
        check("mul_rdy_after", op_ready, 1'b1);
        tick();
        check("mul_done_once", done, 1'b0);
        check("mul_add_ignored", acc, 8'h0F);

        // Abort MUL with reset
        issue(LOAD, 8'h03);
        issue(MUL, 8'h05);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("abort_acc", acc, 8'h00);
        check("abort_rdy", op_ready, 1'b1);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            tick();
        end
        check("abort_no_done", dones, 0);

        // Bus drive and release
        issue(LOAD, 8'hA5);
        enable_output = 1'b1;
        #1;
        check("bus_drive", bus, 8'hA5);
        enable_output = 1'b0;
        #1;
        ext_drv = 8'h3C;
        ext_en  = 1'b1;
        #1;
        check("bus_release", bus, 8'h3C);
        tick();
        check("bus_not_sampled", acc, 8'hA5);
        ext_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
